// File: rtl/vga_scaled_display.sv
// VGA timing generator feeding a two-stage pixel pipeline: a scaled texture read from
// external memory, plus solid, colour-bar and checkerboard test patterns.
module vga_scaled_display #(
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter int          CLK_DIV    = 2,
    parameter int          SCALE_LOG2 = 2,
    parameter bit          SYNC_POL   = 1'b0,
    parameter logic [23:0] BG_COLOR   = 24'h0000FF,
    localparam int         TEX_W      = H_ACTIVE >> SCALE_LOG2,
    localparam int         TEX_H      = V_ACTIVE >> SCALE_LOG2,
    localparam int         AW         = (TEX_W * TEX_H > 1) ? $clog2(TEX_W * TEX_H) : 1
) (
    input  logic          clk_fpga,
    input  logic          rst_n,
    input  logic [1:0]    mode,
    output logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_data,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic [7:0]    o_red,
    output logic [7:0]    o_green,
    output logic [7:0]    o_blue,
    output logic          pix_ce,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic [1:0] {
        MODE_TEXTURE = 2'd0,
        MODE_SOLID   = 2'd1,
        MODE_BARS    = 2'd2,
        MODE_CHECKER = 2'd3
    } mode_e;

    logic [DW-1:0] div_cnt;
    logic [HW-1:0] h_cnt, s1_h;
    logic [VW-1:0] v_cnt, s1_v;
    mode_e         mode_q;
    logic          cnt_active, cnt_hs, cnt_vs, at_wrap;
    logic          s1_active, s1_hs, s1_vs, s1_first;
    logic [AW-1:0] addr_next;
    logic [2:0]    bar;
    logic          checker_on;
    logic [23:0]   color;
    logic          unused_mem_bits;

    assign unused_mem_bits = ^mem_data[31:25];

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk_fpga) begin
        if (!rst_n) begin
            div_cnt <= '0;
            pix_ce  <= 1'b0;
        end else begin
            pix_ce  <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    assign at_wrap = (h_cnt == H_LAST) && (v_cnt == V_LAST);

    always_ff @(posedge clk_fpga) begin
        if (!rst_n) begin
            h_cnt  <= '0;
            v_cnt  <= '0;
            mode_q <= MODE_TEXTURE;
        end else if (pix_ce) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
            // Mode only changes at the frame boundary so a frame is never mixed.
            if (at_wrap) mode_q <= mode_e'(mode);
        end
    end

    assign cnt_active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign cnt_hs     = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    assign cnt_vs     = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    assign addr_next  = AW'((32'(v_cnt) >> SCALE_LOG2) * 32'(TEX_W) + (32'(h_cnt) >> SCALE_LOG2));

    // Stage 1: issue the texel address; it stays put through blanking.
    always_ff @(posedge clk_fpga) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            s1_active <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_first  <= 1'b0;
            s1_h      <= '0;
            s1_v      <= '0;
        end else if (pix_ce) begin
            if (cnt_active) mem_addr <= addr_next;
            s1_active <= cnt_active;
            s1_hs     <= cnt_hs;
            s1_vs     <= cnt_vs;
            s1_first  <= (h_cnt == '0) && (v_cnt == '0);
            s1_h      <= h_cnt;
            s1_v      <= v_cnt;
        end
    end

    assign bar        = 3'(32'(s1_h) / 32'(BAR_W));
    assign checker_on = (((32'(s1_h) >> 4) ^ (32'(s1_v) >> 4)) & 32'd1) != 32'd0;

    always_comb begin
        // NOTE: default assigned first so no path through the case can infer a latch.
        color = 24'h000000;
        case (mode_q)
            MODE_TEXTURE: color = mem_data[24] ? mem_data[23:0] : BG_COLOR;
            MODE_SOLID:   color = BG_COLOR;
            MODE_BARS:    color = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
            MODE_CHECKER: color = {24{checker_on}};
            default:      color = 24'h000000;
        endcase
    end

    // Stage 2: memory has had a full pixel tick to answer the stage-1 address.
    always_ff @(posedge clk_fpga) begin
        if (!rst_n) begin
            {o_red, o_green, o_blue} <= 24'h000000;
            hsync_out   <= ~SYNC_POL;
            vsync_out   <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_ce && s1_first;
            if (pix_ce) begin
                {o_red, o_green, o_blue} <= s1_active ? color : 24'h000000;
                hsync_out <= s1_hs ? SYNC_POL : ~SYNC_POL;
                vsync_out <= s1_vs ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

endmodule
